// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter that shares one DRAM controller command port among N requesters.
// Each grant runs exactly one write or one read. Completion is reported back to the owner with a one-cycle ACK.
module dram_port_arbiter #(
  parameter int N          = 3,
  parameter int WR_CYCLES  = 8,
  parameter int RD_TIMEOUT = 255
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N-1:0]    REQ,
  input  logic [N-1:0]    REQ_WE,
  input  logic [6*N-1:0]  REQ_ADDR,
  input  logic [64*N-1:0] REQ_WDATA,
  output logic [N-1:0]    GNT,
  output logic [N-1:0]    ACK,
  output logic [63:0]     RDATA,
  output logic            ERR,
  output logic            IO_EN,
  output logic [1:0]      IO_MODEL,
  output logic [5:0]      WWL_ADD,
  output logic [5:0]      RWL_ADD,
  output logic [63:0]     WBL_DATA,
  input  logic            RD_DONE,
  input  logic [63:0]     DRAM_DATA_OUT,
  output logic [1:0]      STATE_DBG
);

  // Handshake: a requester holds REQ until its one-cycle ACK; GNT marks the owner from grant through the ACK cycle.
  localparam int PW   = (N > 1) ? $clog2(N) : 1;
  localparam int MAXC = (WR_CYCLES > RD_TIMEOUT) ? WR_CYCLES : RD_TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [63:0]   rdata_q, rdata_d;
  logic [63:0]   wbl_q, wbl_d;
  logic          err_q, err_d;
  logic          io_en_q, io_en_d;
  logic [1:0]    model_q, model_d;
  logic [5:0]    wwl_q, wwl_d;
  logic [5:0]    rwl_q, rwl_d;

  logic [PW-1:0] sel;
  logic [PW-1:0] cand;
  logic          any_req;
  logic          sel_we;
  logic [5:0]    sel_addr;
  logic [63:0]   sel_wdata;
  logic          wr_done;
  logic          rd_ok;
  logic          rd_to;

  // Walk the ring downwards so the lowest offset from the pointer wins.
  always_comb begin
    sel     = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr_q) + k) % N);
      if (REQ[cand]) begin
        sel     = cand;
        any_req = 1'b1;
      end
    end
  end

  assign sel_we    = REQ_WE[sel];
  assign sel_addr  = REQ_ADDR[6*int'(sel) +: 6];
  assign sel_wdata = REQ_WDATA[64*int'(sel) +: 64];

  assign wr_done = (state_q == S_WRITE) && (cnt_q == CW'(WR_CYCLES - 1));
  assign rd_ok   = (state_q == S_READ) && RD_DONE;
  // A read completing on the last allowed cycle wins over the timeout.
  assign rd_to   = (state_q == S_READ) && !RD_DONE && (cnt_q == CW'(RD_TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      wbl_q   <= '0;
      err_q   <= 1'b0;
      io_en_q <= 1'b0;
      model_q <= 2'b00;
      wwl_q   <= '0;
      rwl_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      wbl_q   <= wbl_d;
      err_q   <= err_d;
      io_en_q <= io_en_d;
      model_q <= model_d;
      wwl_q   <= wwl_d;
      rwl_q   <= rwl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = sel_we ? S_WRITE : S_READ;
      S_WRITE: if (wr_done) state_d = S_RESP;
      S_READ:  if (rd_ok || rd_to) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = '0;
    gnt_d   = gnt_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    wbl_d   = wbl_q;
    err_d   = 1'b0;
    io_en_d = io_en_q;
    model_d = model_q;
    wwl_d   = wwl_q;
    rwl_d   = rwl_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << sel;
          ptr_d   = (int'(sel) == N - 1) ? '0 : sel + 1'b1;
          io_en_d = 1'b1;
          if (sel_we) begin
            model_d = 2'b01;
            wwl_d   = sel_addr;
            wbl_d   = sel_wdata;
          end else begin
            model_d = 2'b10;
            rwl_d   = sel_addr;
          end
        end
      end
      S_WRITE, S_READ: begin
        cnt_d = (cnt_q == CW'(MAXC)) ? cnt_q : cnt_q + 1'b1;
        if (wr_done || rd_ok || rd_to) begin
          io_en_d = 1'b0;
          ack_d   = gnt_q;
          err_d   = rd_to;
        end
        if (rd_ok) rdata_d = DRAM_DATA_OUT;
        if (rd_to) rdata_d = '0;
      end
      S_RESP: begin
        gnt_d   = '0;
        model_d = 2'b00;
      end
      default: ;
    endcase
  end

  assign GNT       = gnt_q;
  assign ACK       = ack_q;
  assign RDATA     = rdata_q;
  assign ERR       = err_q;
  assign IO_EN     = io_en_q;
  assign IO_MODEL  = model_q;
  assign WWL_ADD   = wwl_q;
  assign RWL_ADD   = rwl_q;
  assign WBL_DATA  = wbl_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter. Scenario tasks drive stimulus and compare the outputs against a round-robin model.
// That model works from the pending-request mask and a ring pointer.
module tb_dram_port_arbiter;
  localparam int N  = 3;
  localparam int WR = 8;
  localparam int TO = 255;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    REQ, REQ_WE;
  logic [6*N-1:0]  REQ_ADDR;
  logic [64*N-1:0] REQ_WDATA;
  logic [N-1:0]    GNT, ACK;
  logic [63:0]     RDATA;
  logic            ERR, IO_EN;
  logic [1:0]      IO_MODEL;
  logic [5:0]      WWL_ADD, RWL_ADD;
  logic [63:0]     WBL_DATA;
  logic            RD_DONE;
  logic [63:0]     DRAM_DATA_OUT;
  logic [1:0]      STATE_DBG;

  int checks = 0;
  int failures = 0;
  int m_ptr = 0;
  logic [63:0] exp_q[$];

  always #5 CLK = ~CLK;

  dram_port_arbiter #(.N(N), .WR_CYCLES(WR), .RD_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .GNT(GNT), .ACK(ACK), .RDATA(RDATA), .ERR(ERR),
    .IO_EN(IO_EN), .IO_MODEL(IO_MODEL), .WWL_ADD(WWL_ADD), .RWL_ADD(RWL_ADD),
    .WBL_DATA(WBL_DATA), .RD_DONE(RD_DONE), .DRAM_DATA_OUT(DRAM_DATA_OUT),
    .STATE_DBG(STATE_DBG)
  );

  function automatic logic [N-1:0] oh(input int i);
    oh = '0;
    oh[i] = 1'b1;
  endfunction

  // First pending requester at or after the pointer, searching around the ring.
  function automatic int model_pick(input logic [N-1:0] pend);
    for (int k = 0; k < N; k++)
      if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic set_req(input int i, input logic we, input logic [5:0] a, input logic [63:0] d);
    REQ[i] = 1'b1;
    REQ_WE[i] = we;
    REQ_ADDR[6*i +: 6] = a;
    REQ_WDATA[64*i +: 64] = d;
  endtask

  task automatic wait_grant(output int lat);
    lat = 0;
    while (GNT === '0 && lat < 50) begin
      step();
      lat++;
    end
  endtask

  // Called on the first IO_EN-high cycle; counts IO_EN-high cycles and raises RD_DONE on cycle rd_at (0 = never).
  task automatic drive_owner(input int rd_at, input logic [63:0] dat, output int hi);
    hi = 0;
    while (IO_EN === 1'b1 && hi < 400) begin
      hi++;
      if (hi == rd_at) begin
        RD_DONE = 1'b1;
        DRAM_DATA_OUT = dat;
      end else if (!RD_DONE) begin
        DRAM_DATA_OUT = {$urandom, $urandom};
      end
      step();
    end
    RD_DONE = 1'b0;
    DRAM_DATA_OUT = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ = '0; REQ_WE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
    RD_DONE = 1'b0; DRAM_DATA_OUT = '0; m_ptr = 0;
    repeat (3) step();
    checks++; if ({GNT, ACK} !== '0) begin failures++; $display("FAIL reset_gnt_ack: got %b/%b want 0", GNT, ACK); end
    checks++; if ({RDATA, ERR, IO_EN, IO_MODEL} !== '0) begin failures++; $display("FAIL reset_ctrl: rdata=%h err=%b io_en=%b model=%b want 0", RDATA, ERR, IO_EN, IO_MODEL); end
    checks++; if ({WWL_ADD, RWL_ADD, WBL_DATA} !== '0) begin failures++; $display("FAIL reset_addr: wwl=%h rwl=%h wbl=%h want 0", WWL_ADD, RWL_ADD, WBL_DATA); end
    RST = 1'b0;
    step();
    checks++; if (GNT !== '0 || IO_EN !== 1'b0) begin failures++; $display("FAIL idle_no_req: gnt=%b io_en=%b want 0", GNT, IO_EN); end
  endtask

  task automatic test_single_write();
    int hi;
    set_req(0, 1'b1, 6'h05, 64'h0001020304050607);
    step();
    checks++; if (GNT !== 3'b001) begin failures++; $display("FAIL wr_gnt: got %b want 001", GNT); end
    checks++; if (IO_MODEL !== 2'b01 || IO_EN !== 1'b1) begin failures++; $display("FAIL wr_mode: model=%b io_en=%b want 01/1", IO_MODEL, IO_EN); end
    checks++; if (WWL_ADD !== 6'h05 || WBL_DATA !== 64'h0001020304050607) begin failures++; $display("FAIL wr_addr_data: got %h/%h want 05/0001020304050607", WWL_ADD, WBL_DATA); end
    m_ptr = 1;
    drive_owner(0, '0, hi);
    checks++; if (hi !== WR) begin failures++; $display("FAIL wr_io_en_len: got %0d want %0d", hi, WR); end
    checks++; if (ACK !== 3'b001 || ERR !== 1'b0) begin failures++; $display("FAIL wr_ack: ack=%b err=%b want 001/0", ACK, ERR); end
    REQ[0] = 1'b0;
    step();
    checks++; if (ACK !== '0 || GNT !== '0 || IO_MODEL !== 2'b00) begin failures++; $display("FAIL wr_release: ack=%b gnt=%b model=%b want 0", ACK, GNT, IO_MODEL); end
    checks++; if (WBL_DATA !== 64'h0001020304050607) begin failures++; $display("FAIL wbl_retain: got %h want 0001020304050607", WBL_DATA); end
  endtask

  task automatic test_single_read();
    int hi;
    RD_DONE = 1'b1; DRAM_DATA_OUT = 64'hdeadbeefdeadbeef;
    repeat (3) step();
    checks++; if (IO_EN !== 1'b0 || ACK !== '0 || GNT !== '0) begin failures++; $display("FAIL rd_done_idle: io_en=%b ack=%b gnt=%b want 0", IO_EN, ACK, GNT); end
    RD_DONE = 1'b0;
    set_req(1, 1'b0, 6'h16, 64'h1111);
    step();
    checks++; if (GNT !== 3'b010) begin failures++; $display("FAIL rd_gnt: got %b want 010", GNT); end
    checks++; if (IO_MODEL !== 2'b10 || RWL_ADD !== 6'h16 || IO_EN !== 1'b1) begin failures++; $display("FAIL rd_mode: model=%b rwl=%h io_en=%b want 10/16/1", IO_MODEL, RWL_ADD, IO_EN); end
    m_ptr = 2;
    drive_owner(20, 64'h637c777bf26b6fc5, hi);
    checks++; if (hi !== 20) begin failures++; $display("FAIL rd_io_en_len: got %0d want 20", hi); end
    checks++; if (ACK !== 3'b010 || ERR !== 1'b0 || RDATA !== 64'h637c777bf26b6fc5) begin failures++; $display("FAIL rd_ack: ack=%b err=%b rdata=%h want 010/0/637c777bf26b6fc5", ACK, ERR, RDATA); end
    REQ[1] = 1'b0;
    step();
    checks++; if (ACK !== '0 || IO_MODEL !== 2'b00 || IO_EN !== 1'b0) begin failures++; $display("FAIL rd_release: ack=%b model=%b io_en=%b want 0", ACK, IO_MODEL, IO_EN); end
  endtask

  task automatic test_round_robin();
    int hi, lat, e;
    RST = 1'b1; step(); RST = 1'b0; m_ptr = 0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 6'(i + 1), {$urandom, $urandom});
    for (int g = 0; g < 8; g++) begin
      e = model_pick(REQ);
      wait_grant(lat);
      checks++; if (GNT !== oh(e) || lat != 1) begin failures++; $display("FAIL rr_grant%0d: gnt=%b lat=%0d want %b lat 1", g, GNT, lat, oh(e)); end
      m_ptr = (e + 1) % N;
      drive_owner(0, '0, hi);
      checks++; if (hi !== WR || ACK !== oh(e)) begin failures++; $display("FAIL rr_ack%0d: len=%0d ack=%b want %0d/%b", g, hi, ACK, WR, oh(e)); end
      if (g == 6) REQ[1] = 1'b0;
      step();
      checks++; if (IO_EN !== 1'b0 || GNT !== '0) begin failures++; $display("FAIL rr_gap%0d: io_en=%b gnt=%b want 0", g, IO_EN, GNT); end
      if (g == 7) REQ = '0;
    end
    step();
  endtask

  task automatic test_read_timeout();
    int hi, lat, e;
    set_req(2, 1'b0, 6'h2a, '0);
    e = model_pick(REQ);
    wait_grant(lat);
    checks++; if (GNT !== oh(e)) begin failures++; $display("FAIL to_gnt: got %b want %b", GNT, oh(e)); end
    m_ptr = (e + 1) % N;
    set_req(0, 1'b1, 6'h3f, 64'hfeedface00000001);
    drive_owner(0, '0, hi);
    checks++; if (hi !== TO) begin failures++; $display("FAIL to_io_en_len: got %0d want %0d", hi, TO); end
    checks++; if (ACK !== 3'b100 || ERR !== 1'b1 || RDATA !== '0) begin failures++; $display("FAIL to_ack: ack=%b err=%b rdata=%h want 100/1/0", ACK, ERR, RDATA); end
    REQ[2] = 1'b0;
    step();
    checks++; if (ERR !== 1'b0 || ACK !== '0) begin failures++; $display("FAIL to_err_clear: err=%b ack=%b want 0", ERR, ACK); end
    e = model_pick(REQ);
    wait_grant(lat);
    checks++; if (GNT !== oh(e) || WWL_ADD !== 6'h3f) begin failures++; $display("FAIL to_next_gnt: gnt=%b wwl=%h want %b/3f", GNT, WWL_ADD, oh(e)); end
    m_ptr = (e + 1) % N;
    drive_owner(0, '0, hi);
    checks++; if (hi !== WR || ACK !== oh(e) || ERR !== 1'b0) begin failures++; $display("FAIL to_next_ack: len=%0d ack=%b err=%b", hi, ACK, ERR); end
    REQ[0] = 1'b0;
    step();
    set_req(1, 1'b0, 6'h01, '0);
    e = model_pick(REQ);
    wait_grant(lat);
    m_ptr = (e + 1) % N;
    drive_owner(TO, 64'h0badc0de0badc0de, hi);
    checks++; if (hi !== TO || ERR !== 1'b0 || RDATA !== 64'h0badc0de0badc0de || ACK !== oh(e)) begin failures++; $display("FAIL to_boundary: len=%0d err=%b rdata=%h ack=%b", hi, ERR, RDATA, ACK); end
    REQ[1] = 1'b0;
    step();
  endtask

  task automatic test_input_stability();
    int hi, lat, e;
    set_req(0, 1'b1, 6'h21, 64'hcafef00d12345678);
    e = model_pick(REQ);
    wait_grant(lat);
    m_ptr = (e + 1) % N;
    repeat (2) step();
    REQ_ADDR[5:0] = 6'h0e; REQ_WDATA[63:0] = 64'h5555aaaa5555aaaa; REQ_WE[0] = 1'b0; REQ[0] = 1'b0;
    step();
    checks++; if (WWL_ADD !== 6'h21 || WBL_DATA !== 64'hcafef00d12345678 || IO_MODEL !== 2'b01) begin failures++; $display("FAIL stab_latched: wwl=%h wbl=%h model=%b", WWL_ADD, WBL_DATA, IO_MODEL); end
    drive_owner(0, '0, hi);
    checks++; if (hi + 3 !== WR || ACK !== 3'b001) begin failures++; $display("FAIL stab_ack: len=%0d ack=%b want %0d/001", hi + 3, ACK, WR); end
    step();
    checks++; if (GNT !== '0 || ACK !== '0) begin failures++; $display("FAIL stab_no_regrant: gnt=%b ack=%b want 0", GNT, ACK); end
    step();
  endtask

  task automatic test_random();
    int hi, e, rd_at, exp_hi;
    logic ewe, eerr;
    logic [5:0] ea;
    logic [63:0] ed, dat;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++)
        if (!REQ[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)), 6'($urandom), {$urandom, $urandom});
      if (REQ == '0) set_req($urandom_range(0, N - 1), 1'b0, 6'($urandom), {$urandom, $urandom});
      e = model_pick(REQ);
      ewe = REQ_WE[e]; ea = REQ_ADDR[6*e +: 6]; ed = REQ_WDATA[64*e +: 64];
      step();
      checks++; if (GNT !== oh(e)) begin failures++; $display("FAIL rnd_gnt%0d: got %b want %b", t, GNT, oh(e)); end
      checks++; if (IO_MODEL !== (ewe ? 2'b01 : 2'b10) || (ewe ? WWL_ADD : RWL_ADD) !== ea) begin failures++; $display("FAIL rnd_cmd%0d: model=%b wwl=%h rwl=%h want we=%b addr=%h", t, IO_MODEL, WWL_ADD, RWL_ADD, ewe, ea); end
      if (ewe) begin
        checks++; if (WBL_DATA !== ed) begin failures++; $display("FAIL rnd_wbl%0d: got %h want %h", t, WBL_DATA, ed); end
      end
      m_ptr = (e + 1) % N;
      REQ_ADDR[6*e +: 6] = 6'($urandom); REQ_WDATA[64*e +: 64] = {$urandom, $urandom};
      REQ_WE[e] = ~REQ_WE[e];
      if ($urandom_range(0, 3) == 0) REQ[e] = 1'b0;
      dat = {$urandom, $urandom};
      if (ewe) begin
        rd_at = $urandom_range(1, WR); exp_hi = WR; eerr = 1'b0;
      end else begin
        rd_at = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 30);
        exp_hi = (rd_at == 0) ? TO : rd_at;
        eerr = (rd_at == 0);
        exp_q.push_back((rd_at == 0) ? 64'h0 : dat);
      end
      drive_owner(rd_at, dat, hi);
      checks++; if (hi !== exp_hi || ACK !== oh(e) || ERR !== eerr) begin failures++; $display("FAIL rnd_done%0d: len=%0d ack=%b err=%b want %0d/%b/%b", t, hi, ACK, ERR, exp_hi, oh(e), eerr); end
      if (!ewe && exp_q.size() > 0) begin
        ed = exp_q.pop_front();
        checks++; if (RDATA !== ed) begin failures++; $display("FAIL rnd_rdata%0d: got %h want %h", t, RDATA, ed); end
      end
      REQ[e] = 1'b0;
      step();
      checks++; if (ACK !== '0 || IO_EN !== 1'b0 || GNT !== '0) begin failures++; $display("FAIL rnd_gap%0d: ack=%b io_en=%b gnt=%b want 0", t, ACK, IO_EN, GNT); end
    end
    REQ = '0;
    step();
  endtask

  task automatic test_reset_mid_read();
    int hi, lat, e;
    bit stray;
    set_req(2, 1'b0, 6'h33, '0);
    e = model_pick(REQ);
    wait_grant(lat);
    repeat (5) step();
    #2 RST = 1'b1;
    #1;
    checks++; if ({GNT, ACK, ERR, IO_EN, IO_MODEL} !== '0) begin failures++; $display("FAIL rst_mid_ctrl: gnt=%b ack=%b err=%b io_en=%b model=%b want 0", GNT, ACK, ERR, IO_EN, IO_MODEL); end
    checks++; if ({RDATA, WWL_ADD, RWL_ADD, WBL_DATA} !== '0) begin failures++; $display("FAIL rst_mid_data: rdata=%h wwl=%h rwl=%h wbl=%h want 0", RDATA, WWL_ADD, RWL_ADD, WBL_DATA); end
    step();
    RST = 1'b0; m_ptr = 0; REQ = '0;
    set_req(1, 1'b0, 6'h09, '0);
    e = model_pick(REQ);
    stray = 1'b0;
    wait_grant(lat);
    checks++; if (GNT !== oh(e) || lat != 1) begin failures++; $display("FAIL rst_regrant: gnt=%b lat=%0d want %b lat 1", GNT, lat, oh(e)); end
    m_ptr = (e + 1) % N;
    drive_owner(3, 64'h0123456789abcdef, hi);
    checks++; if (ACK !== 3'b010 || RDATA !== 64'h0123456789abcdef) begin failures++; $display("FAIL rst_after_ack: ack=%b rdata=%h want 010/0123456789abcdef", ACK, RDATA); end
    REQ = '0;
    repeat (3) begin
      step();
      if (ACK !== '0) stray = 1'b1;
    end
    checks++; if (stray) begin failures++; $display("FAIL rst_stray_ack: got 1 want 0"); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_read_timeout();
    test_input_stability();
    test_random();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single 16-core DRAM write/read controller command port between N requesters, e.g. the key/SBOX programmer, the AES round-key fetcher and the CIM SBOX lookup engine.
- Accepts one transaction per grant (one 64-bit word write, or one read) using round-robin arbitration.
- Drives IO_EN, IO_MODEL, WWL_ADD, RWL address and WBL data to the controller.
- Returns completion, read data and timeout status to the granted requester.

Parameters:
- N, 3, number of requesters (2..8).
- WR_CYCLES, 8, cycles IO_EN is held high for a write (>=1).
- RD_TIMEOUT, 255, maximum cycles to wait for RD_DONE before aborting a read (>=1).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ  in  N  per-requester request; held high until ACK.
- REQ_WE  in  N  1 = write, 0 = read; sampled at grant.
- REQ_ADDR  in  6*N  word address, requester i at bits [6i+5:6i].
- REQ_WDATA  in  64*N  write data, requester i at bits [64i+63:64i].
- GNT  out  N  one-hot; the currently owning requester.
- ACK  out  N  one-cycle completion pulse to the owner.
- RDATA  out  64  captured read data; valid while ACK is high on a read.
- ERR  out  1  high with ACK when a read timed out.
- IO_EN  out  1  controller enable.
- IO_MODEL  out  2  controller mode: 2'b01 = write, 2'b10 = read, 2'b00 = idle.
- WWL_ADD  out  6  write wordline address.
- RWL_ADD  out  6  read wordline address.
- WBL_DATA  out  64  write bitline data, replicated by the integrator to all 16 cores.
- RD_DONE  in  1  controller read-complete indication; level or pulse.
- DRAM_DATA_OUT  in  64  controller read data, valid when RD_DONE is high.

Behaviour:
- Reset values: GNT=0, ACK=0, RDATA=0, ERR=0, IO_EN=0, IO_MODEL=0, WWL_ADD=0, RWL_ADD=0, WBL_DATA=0. Round-robin pointer=0, state=IDLE.
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - If any REQ is high, select the first requesting index at or after the pointer, searching cyclically modulo N.
  - Next cycle: GNT=onehot(sel); latch REQ_WE/ADDR/WDATA of sel into the outputs.
  - Pointer <= (sel+1) mod N, updated at grant, not at completion.
  - If sel is a write: IO_MODEL=01, WWL_ADD=addr, WBL_DATA=wdata, IO_EN=1, go to WRITE.
  - If sel is a read: IO_MODEL=10, RWL_ADD=addr, IO_EN=1, go to READ.
  - Grant latency is 1 cycle from REQ to GNT/IO_EN.
- WRITE:
  - A counter holds IO_EN high for exactly WR_CYCLES cycles.
  - Then IO_EN=0 and go to RESP with ERR=0.
- READ:
  - IO_EN is held high.
  - On the first cycle with RD_DONE=1: capture DRAM_DATA_OUT into RDATA, IO_EN=0, go to RESP with ERR=0.
  - If RD_DONE is not seen within RD_TIMEOUT cycles of IO_EN rising: IO_EN=0, RDATA=0, go to RESP with ERR=1.
  - RD_DONE arriving in the same cycle as the timeout counts as success.
- RESP:
  - ACK[owner]=1 for exactly one cycle.
  - ERR is valid that cycle and cleared the next.
  - Next cycle: GNT=0, IO_MODEL=00, go to IDLE.
  - Minimum 1 idle cycle (IO_EN=0) between consecutive transactions, which gives the controller a clean IO_EN falling edge.
- Requester inputs are latched at grant. Changes to REQ_ADDR/WDATA/WE during ownership are ignored.
- If REQ drops during ownership, the transaction still completes and ACK is still pulsed.
- RD_DONE while IDLE or WRITE is ignored.
- WBL_DATA and RWL_ADD retain their last values when idle. The controller qualifies them by IO_EN.
- Counters are sized by $clog2 of the parameter, and the timeout counter saturates.
- RST asserted mid-transaction: all outputs return to reset values immediately (asynchronously). Any in-flight transaction is dropped with no ACK.

Test Plan:
- Single write: REQ[0]=1, WE=1, ADDR=6'h05, WDATA=64'h0001020304050607 -> GNT=001 next cycle; IO_MODEL=01, WWL_ADD=05, IO_EN high exactly 8 cycles; ACK[0] pulse 1 cycle later; ERR=0.
- Single read: REQ[1] read, ADDR=6'h16; RD_DONE raised 20 cycles after IO_EN with DRAM_DATA_OUT=64'h637c777bf26b6fc5 -> RDATA equals that value with ACK[1]; IO_EN low the cycle after RD_DONE.
- Round robin: REQ=111 held continuously -> grant order 0,1,2,0,1,2 with IO_EN low at least 1 cycle between each. Then REQ=101 after granting 0 -> next grant is 2.
- Read timeout: read with RD_DONE never asserted -> IO_EN high exactly 255 cycles; ACK with ERR=1 and RDATA=0; the next requester is served normally afterwards.
- Input stability: change REQ_ADDR and WDATA and drop REQ[0] mid-write -> WWL_ADD/WBL_DATA keep the values latched at grant; ACK[0] is still pulsed.
- Reset mid-read: assert RST 5 cycles into READ -> all outputs are 0 immediately. After release with REQ=010, the grant goes to requester 1 (pointer reset to 0, so the search starts at 0) and no stray ACK occurs.
